// File: rtl/alu_op_issuer.sv
// alu_op_issuer: drives one operation at a time into an external 3-bit
// add/subtract ALU under test and checks its result against a golden model.
// Each operation presents the operand, parity and op-code drive registers,
// holds them for SETTLE cycles, captures the ALU result for one cycle, and
// then offers the result on a valid/ready response port. A saturating counter
// tracks how many responses disagreed with the golden model.
module alu_op_issuer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,

  // Request side
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [2:0] req_a,
  input  logic [2:0] req_b,
  input  logic       inj_par,

  // Drive to the ALU under test
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       B0,
  output logic       B1,
  output logic       B2,
  output logic       PAR,
  output logic       C0,
  output logic       C1,
  output logic       C2,

  // Result from the ALU under test
  input  logic       X0,
  input  logic       X1,
  input  logic       X2,
  input  logic       XC,
  input  logic       errorout,

  // Response side
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_sum,
  output logic       rsp_carry,
  output logic       rsp_hw_err,
  output logic       rsp_mismatch,
  output logic [7:0] err_count
);

  // Out-of-range settle lengths are clamped to the supported 1..15 window.
  localparam int         SETTLE_C  = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_C);

  // Operation codes on req_op
  localparam logic [1:0] OP_ADD = 2'b00;  // A + B
  localparam logic [1:0] OP_SUB = 2'b01;  // A - B
  localparam logic [1:0] OP_RSB = 2'b10;  // B - A
  localparam logic [1:0] OP_ILL = 2'b11;  // illegal code, ALU must flag error

  // FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  // One-hot op-code drive, returned as {C0,C1,C2}; the illegal code drives
  // no line at all so the ALU sees an invalid one-hot pattern.
  function automatic logic [2:0] op_to_c(input logic [1:0] op);
    case (op)
      OP_ADD:  return 3'b100;
      OP_SUB:  return 3'b010;
      OP_RSB:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // State and counters
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;

  // ALU drive registers plus the request attributes the golden model needs
  logic [2:0] a_q,   a_d;
  logic [2:0] b_q,   b_d;
  logic [2:0] c_q,   c_d;      // {C0,C1,C2}
  logic       par_q, par_d;
  logic [1:0] op_q,  op_d;
  logic       inj_q, inj_d;

  // Captured response
  logic [2:0] rsp_sum_q,      rsp_sum_d;
  logic       rsp_carry_q,    rsp_carry_d;
  logic       rsp_hw_err_q,   rsp_hw_err_d;
  logic       rsp_mismatch_q, rsp_mismatch_d;
  logic [7:0] err_count_q,    err_count_d;

  // Golden model signals
  logic [2:0] gold_a;
  logic [2:0] gold_b;
  logic [3:0] gold_res;        // {carry, sum}
  logic [3:0] alu_res;         // {XC, X2, X1, X0}
  logic       exp_err;
  logic       mismatch;

  // Golden result and comparison against the ALU, from the held drive registers.
  always_comb begin
    // Negating a 3-bit operand modulo 8 is plain two's-complement wraparound.
    gold_a   = (op_q == OP_RSB) ? (3'd0 - a_q) : a_q;
    gold_b   = (op_q == OP_SUB) ? (3'd0 - b_q) : b_q;
    gold_res = {1'b0, gold_a} + {1'b0, gold_b};
    alu_res  = {XC, X2, X1, X0};
    exp_err  = (op_q == OP_ILL) | inj_q;
    // When an error is expected the sum/carry carry no meaning and are ignored.
    mismatch = (errorout != exp_err) | (!exp_err & (alu_res != gold_res));
  end

  // Next-state logic for the FSM, drive registers and response registers.
  always_comb begin
    // NOTE: every variable gets a hold-value default before any branch, so
    // paths that do not assign it cannot infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    c_d            = c_q;
    par_d          = par_q;
    op_d           = op_q;
    inj_d          = inj_q;
    rsp_sum_d      = rsp_sum_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_hw_err_d   = rsp_hw_err_q;
    rsp_mismatch_d = rsp_mismatch_q;
    err_count_d    = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          c_d     = op_to_c(req_op);
          // Odd parity over the six operand bits, flipped on request so the
          // ALU's parity checker can be exercised.
          par_d   = ~(^{req_a, req_b}) ^ inj_par;
          op_d    = req_op;
          inj_d   = inj_par;
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_CAPTURE: begin
        rsp_sum_d      = {X2, X1, X0};
        rsp_carry_d    = XC;
        rsp_hw_err_d   = errorout;
        rsp_mismatch_d = mismatch;
        if (mismatch && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      a_q            <= 3'd0;
      b_q            <= 3'd0;
      c_q            <= op_to_c(OP_ADD);
      par_q          <= 1'b1;
      op_q           <= OP_ADD;
      inj_q          <= 1'b0;
      rsp_sum_q      <= 3'd0;
      rsp_carry_q    <= 1'b0;
      rsp_hw_err_q   <= 1'b0;
      rsp_mismatch_q <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      c_q            <= c_d;
      par_q          <= par_d;
      op_q           <= op_d;
      inj_q          <= inj_d;
      rsp_sum_q      <= rsp_sum_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_hw_err_q   <= rsp_hw_err_d;
      rsp_mismatch_q <= rsp_mismatch_d;
      err_count_q    <= err_count_d;
    end
  end

  // Handshake flags decode directly from the registered state.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);

  // Drive outputs straight from registers so the ALU sees glitch-free inputs.
  assign {A2, A1, A0} = a_q;
  assign {B2, B1, B0} = b_q;
  assign {C0, C1, C2} = c_q;
  assign PAR          = par_q;

  assign rsp_sum      = rsp_sum_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_hw_err   = rsp_hw_err_q;
  assign rsp_mismatch = rsp_mismatch_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Testbench for alu_op_issuer: directed vector table plus hand-written
// sequences for saturation, response back-pressure and mid-operation reset.
module tb_alu_op_issuer;

  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [2:0] req_a, req_b;
  logic       inj_par;
  logic       A0, A1, A2, B0, B1, B2, PAR, C0, C1, C2;
  logic       X0, X1, X2, XC, errorout;
  logic       rsp_valid, rsp_ready;
  logic [2:0] rsp_sum;
  logic       rsp_carry, rsp_hw_err, rsp_mismatch;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .inj_par(inj_par),
    .A0(A0), .A1(A1), .A2(A2), .B0(B0), .B1(B1), .B2(B2),
    .PAR(PAR), .C0(C0), .C1(C1), .C2(C2),
    .X0(X0), .X1(X1), .X2(X2), .XC(XC), .errorout(errorout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_hw_err(rsp_hw_err),
    .rsp_mismatch(rsp_mismatch), .err_count(err_count)
  );

  // One directed operation: request, what the ALU answers, and what the
  // issuer must show (sum/carry/hw_err are echoed from the ALU answer).
  typedef struct {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic       inj;
    logic [2:0] x_sum;
    logic       x_carry;
    logic       x_err;
    logic [2:0] e_c;      // {C0,C1,C2}
    logic       e_par;
    logic       e_mis;
    logic [7:0] e_cnt;    // err_count after this response
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " req_ready"},    32'(req_ready),    32'd1);
    check({tag, " rsp_valid"},    32'(rsp_valid),    32'd0);
    check({tag, " rsp_sum"},      32'(rsp_sum),      32'd0);
    check({tag, " rsp_carry"},    32'(rsp_carry),    32'd0);
    check({tag, " rsp_hw_err"},   32'(rsp_hw_err),   32'd0);
    check({tag, " rsp_mismatch"}, 32'(rsp_mismatch), 32'd0);
    check({tag, " err_count"},    32'(err_count),    32'd0);
    check({tag, " A"},            32'({A2, A1, A0}), 32'd0);
    check({tag, " B"},            32'({B2, B1, B0}), 32'd0);
    check({tag, " C"},            32'({C0, C1, C2}), 32'b100);
    check({tag, " PAR"},          32'(PAR),          32'd1);
  endtask

  // Present a request for one cycle and set the ALU answer alongside it.
  task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic inj, input logic [2:0] xs, input logic xc, input logic xe);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b; inj_par = inj;
    {X2, X1, X0} = xs; XC = xc; errorout = xe;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; returns cycles counted since acceptance.
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    cyc;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    check({t, " req_ready before"}, 32'(req_ready), 32'd1);
    issue(v.op, v.a, v.b, v.inj, v.x_sum, v.x_carry, v.x_err);
    // First SETTLE cycle: drive registers loaded, request blocked.
    check({t, " A"},         32'({A2, A1, A0}), 32'(v.a));
    check({t, " B"},         32'({B2, B1, B0}), 32'(v.b));
    check({t, " C"},         32'({C0, C1, C2}), 32'(v.e_c));
    check({t, " PAR"},       32'(PAR),          32'(v.e_par));
    check({t, " req_ready"}, 32'(req_ready),    32'd0);
    wait_rsp(cyc);
    check({t, " latency"},      32'(cyc),          32'(SETTLE + 2));
    check({t, " rsp_sum"},      32'(rsp_sum),      32'(v.x_sum));
    check({t, " rsp_carry"},    32'(rsp_carry),    32'(v.x_carry));
    check({t, " rsp_hw_err"},   32'(rsp_hw_err),   32'(v.x_err));
    check({t, " rsp_mismatch"}, 32'(rsp_mismatch), 32'(v.e_mis));
    check({t, " err_count"},    32'(err_count),    32'(v.e_cnt));
    // Back-pressure: response holds while rsp_ready is low.
    repeat (2) @(negedge clk);
    check({t, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({t, " hold req_ready"}, 32'(req_ready), 32'd0);
    check({t, " hold rsp_sum"},   32'(rsp_sum),   32'(v.x_sum));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({t, " rsp_valid drop"}, 32'(rsp_valid),    32'd0);
    check({t, " back to idle"},   32'(req_ready),    32'd1);
    check({t, " A retained"},     32'({A2, A1, A0}), 32'(v.a));
    check({t, " C retained"},     32'({C0, C1, C2}), 32'(v.e_c));
  endtask

  // Fast operation used by the saturation loop: ALU stuck at X0=1 on 0+0.
  task automatic quiet_mismatch_op();
    int cyc;
    issue(2'b00, 3'd0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
    wait_rsp(cyc);
    if (!rsp_valid) check("sat rsp timeout", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 3'd0; req_b = 3'd0;
    inj_par = 1'b0; rsp_ready = 1'b0;
    {X2, X1, X0} = 3'd0; XC = 1'b0; errorout = 1'b0;

    //                op     a     b     inj   x_sum x_c   x_err C       PAR   mis   cnt
    vecs[0]  = '{2'b00, 3'd3, 3'd2, 1'b0, 3'd5, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{2'b01, 3'd5, 3'd3, 1'b0, 3'd2, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{2'b11, 3'd1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{2'b11, 3'd1, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 8'd1};
    vecs[4]  = '{2'b00, 3'd2, 3'd1, 1'b1, 3'd3, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 8'd1};
    vecs[5]  = '{2'b10, 3'd1, 3'd3, 1'b0, 3'd2, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{2'b00, 3'd7, 3'd7, 1'b0, 3'd6, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 8'd2};
    vecs[7]  = '{2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 8'd3};
    vecs[8]  = '{2'b01, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 8'd3};
    vecs[9]  = '{2'b10, 3'd4, 3'd4, 1'b0, 3'd0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 8'd3};
    vecs[10] = '{2'b01, 3'd3, 3'd5, 1'b1, 3'd7, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 8'd3};
    vecs[11] = '{2'b10, 3'd5, 3'd2, 1'b0, 3'd3, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 8'd4};
    vecs[12] = '{2'b00, 3'd1, 3'd1, 1'b1, 3'd2, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 8'd5};

    // Reset state, observed while rst_n is still asserted.
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Saturation: err_count starts at 5 here.
    for (int i = 0; i < 249; i++) quiet_mismatch_op();
    check("sat at 254", 32'(err_count), 32'd254);
    quiet_mismatch_op();
    check("sat at 255", 32'(err_count), 32'd255);
    for (int i = 0; i < 50; i++) quiet_mismatch_op();
    check("sat hold 255", 32'(err_count), 32'd255);

    // Long back-pressure with a pending response.
    issue(2'b00, 3'd0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
    wait_rsp(cyc);
    repeat (10) @(negedge clk);
    check("bp rsp_valid",    32'(rsp_valid),    32'd1);
    check("bp req_ready",    32'(req_ready),    32'd0);
    check("bp rsp_mismatch", 32'(rsp_mismatch), 32'd1);
    check("bp err_count",    32'(err_count),    32'd255);

    // Reset while RESP is pending: response is dropped and the count cleared.
    do_reset();
    rst_n = 1'b1;
    check_reset_state("rst in resp");

    // Reset during SETTLE: no response ever appears, count stays 0.
    issue(2'b00, 3'd7, 3'd5, 1'b1, 3'd1, 1'b1, 1'b0);
    check("pre-abort in settle", 32'(req_ready), 32'd0);
    do_reset();
    rst_n = 1'b1;
    check_reset_state("rst in settle");
    repeat (SETTLE + 3) @(negedge clk);
    check("abort no rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort err_count",    32'(err_count), 32'd0);

    // After the aborts a fresh operation still works end to end.
    run_vec(100, '{2'b00, 3'd3, 3'd2, 1'b0, 3'd5, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 8'd0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
